// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: shared state encoding and default sizes for the shift sequencer
package shift_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEF_BW = 4;
  localparam int DEF_STEP = 2;
  localparam int DEF_AW = 8;
endpackage

// File: rtl/shift_sequencer_shift_step.sv
// shift_step: one combinational left shift by d (0..STEP) with fill bit and MSB-out bit
module shift_step import shift_sequencer_pkg::*; #(
  parameter int BW = DEF_BW,
  parameter int STEP = DEF_STEP,
  parameter int DW = $clog2(STEP + 1)
) (
  input  logic [BW-1:0] x,
  input  logic [DW-1:0] d,
  input  logic          fin,
  input  logic          e_in,
  output logic [BW-1:0] y,
  output logic          e_out
);
  assign {e_out, y} = (BW + 1)'(({e_in, x, {BW{fin}}} << d) >> BW);
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin two-requester multi-cycle left shifter with fill bit and handshake response
module shift_sequencer import shift_sequencer_pkg::*; #(
  parameter int BW = DEF_BW,
  parameter int STEP = DEF_STEP,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [BW-1:0] req0_a,
  input  logic [AW-1:0] req0_amt,
  input  logic          req0_fin,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [BW-1:0] req1_a,
  input  logic [AW-1:0] req1_amt,
  input  logic          req1_fin,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [BW-1:0] rsp_y,
  output logic          rsp_e,
  output logic          rsp_id,
  output logic          busy
);
  localparam int DW = $clog2(STEP + 1);
  state_t state_q, state_d;
  logic ptr_q, ptr_d, id_q, id_d, fin_q, fin_d, e_q, e_d, e_s;
  logic [AW-1:0] rem_q, rem_d;
  logic [BW-1:0] work_q, work_d, work_s;
  logic [DW-1:0] d;
  logic grant, idle;
  assign idle = state_q == IDLE;
  assign grant = req0_valid && req1_valid ? ptr_q : req1_valid;
  assign req0_ready = !rst && idle && req0_valid && !grant;
  assign req1_ready = !rst && idle && req1_valid && grant;
  assign d = rem_q < AW'(STEP) ? DW'(rem_q) : DW'(STEP);
  shift_step #(.BW(BW), .STEP(STEP), .DW(DW)) u_step (
    .x(work_q),
    .d(d),
    .fin(fin_q),
    .e_in(e_q),
    .y(work_s),
    .e_out(e_s)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    fin_d = fin_q;
    e_d = e_q;
    rem_d = rem_q;
    work_d = work_q;
    case (state_q)
      IDLE: if (req0_valid || req1_valid) begin
        ptr_d = !grant;
        id_d = grant;
        fin_d = grant ? req1_fin : req0_fin;
        rem_d = grant ? req1_amt : req0_amt;
        work_d = grant ? req1_a : req0_a;
        e_d = 1'b0;
        state_d = rem_d == '0 ? DONE : SHIFT;
      end
      SHIFT: begin
        work_d = work_s;
        e_d = e_s;
        rem_d = rem_q - AW'(d);
        state_d = rem_d == '0 ? DONE : SHIFT;
      end
      DONE: state_d = rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      id_q <= 1'b0;
      fin_q <= 1'b0;
      e_q <= 1'b0;
      rem_q <= '0;
      work_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      fin_q <= fin_d;
      e_q <= e_d;
      rem_q <= rem_d;
      work_q <= work_d;
    end
  end
  assign rsp_valid = state_q == DONE;
  assign busy = !idle;
  assign rsp_y = work_q;
  assign rsp_e = e_q;
  assign rsp_id = id_q;
endmodule
